fwd_scoreboard_unit: RTL and testbench
======================================

Name: fwd_scoreboard_unit

Overview:
- Parametrised successor to the two-source, two-stage pipeline forwarding logic.
- Generates forward selects for NUM_SRC decode-stage source operands across FWD_DEPTH downstream stages, plus a bypass from the long-latency completion bus.
- Owns a register scoreboard for in-flight multi-cycle ops (mul/div) and produces the decode stall for load-use, RAW-on-pending, WAW-on-pending and scoreboard-full hazards.
- Sits beside the ID stage; its outputs drive the operand muxes and the IF/ID hold.

Parameters:
NUM_SRC, 2, number of source operands checked per decode instruction
FWD_DEPTH, 2, forwarding stages; index 0 is youngest (EX/MEM), FWD_DEPTH-1 oldest
REG_AW, 5, register address width; register 0 is hard-wired zero
MAX_PEND, 4, maximum in-flight long-latency ops
SEL_W, $clog2(FWD_DEPTH+2), width of one forward select

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
flush  in  1  decode instruction squashed this cycle
id_rs  in  NUM_SRC*REG_AW  source register numbers, src i at [i*REG_AW +: REG_AW]
id_rs_used  in  NUM_SRC  source i actually read
stage_rd  in  FWD_DEPTH*REG_AW  destination register of each downstream stage
stage_rw  in  FWD_DEPTH  stage writes rd
stage_is_load  in  1  stage-0 instruction is a load (data not yet available)
issue_valid  in  1  decode instruction wants to issue
issue_long  in  1  decode instruction is long-latency
issue_rd  in  REG_AW  destination of decode instruction
done_valid  in  1  long op completes this cycle (result on completion bus)
done_rd  in  REG_AW  destination of completing long op
fwd_sel  out  NUM_SRC*SEL_W  per-source select: 0 regfile, k+1 stage k, FWD_DEPTH+1 completion bus
stall  out  1  hold decode
sb_full  out  1  MAX_PEND ops in flight
err  out  1  sticky: completion for a non-pending register
stall_cycles  out  32  saturating count of stalled cycles

Behaviour:
- Reset (async): pending[] = 0, pend_cnt = 0, err = 0, stall_cycles = 0. With inputs idle, outputs are fwd_sel = 0, stall = 0, sb_full = 0.
- Forward select (combinational), per source i with rs = id_rs[i]:
  - rs == 0 or !id_rs_used[i] -> 0.
  - Else the lowest k with stage_rw[k] and stage_rd[k] == rs -> k+1 (youngest wins).
  - Else if done_valid and done_rd == rs -> FWD_DEPTH+1.
  - Else 0.
- Hazards (combinational):
  - load_use: some used, nonzero source has selected stage 0 while stage_is_load = 1.
  - raw_pend: used, nonzero rs with pending[rs] = 1, no stage match, and not (done_valid and done_rd == rs).
  - waw_pend: issue_valid, issue_rd != 0, pending[issue_rd] = 1, and not (done_valid and done_rd == issue_rd).
  - full_hz: issue_valid & issue_long & (pend_cnt == MAX_PEND) & !(done_valid & pending[done_rd]).
  - stall = !flush & (load_use | raw_pend | waw_pend | full_hz).
- Allocation: alloc = issue_valid & issue_long & !stall & !flush & issue_rd != 0. It sets pending[issue_rd] at the clock edge.
- Completion: done_valid with pending[done_rd] = 1 clears the bit. If done_rd is not pending (and not 0), ignore it and set err (sticky until reset). done_rd == 0 is ignored silently.
- Same-register alloc and done in one cycle: the bit ends set (new op wins). pend_cnt is unchanged.
- pend_cnt update: +1 on alloc, -1 on valid clear, net when both occur. It never exceeds MAX_PEND or underflows.
- sb_full = (pend_cnt == MAX_PEND), registered state.
- stall_cycles increments on each cycle with stall = 1 and saturates at 2^32-1.
- flush does not clear the scoreboard; issued long ops still complete.
- Reset asserted mid-operation drops all pending state immediately.

Decomposition:
- Shared package/header: SEL_REGFILE = 0, SEL_COMPLETION(FWD_DEPTH) encoding, and the REG_AW default shared with the regfile and decoder.
- One natural sub-module: fwd_src_match. It holds the per-source priority match over stages and the completion bus, and is instantiated NUM_SRC times via generate.

Test Plan:
- Priority: rs1 = 5, stage0 rd = 5 rw = 1, stage1 rd = 5 rw = 1 -> fwd_sel[0] = 1, stall = 0. Same with stage0 rw = 0 -> fwd_sel[0] = 2. rs = 0 with matching stage rd = 0 -> fwd_sel = 0.
- Load-use: stage0 load rd = 7, rs2 = 7 used -> stall = 1. Next cycle, load moved to stage1 -> stall = 0, fwd_sel[1] = 2.
- Scoreboard RAW: issue long rd = 9 -> pending. Later rs1 = 9 -> stall = 1. Cycle with done_rd = 9 -> stall = 0, fwd_sel[0] = FWD_DEPTH+1. Next cycle pending[9] = 0, fwd_sel[0] = 0.
- Full: 4 long issues (rd 1..4) -> sb_full = 1, 5th long issue stalls. Same cycle done_rd = 1 -> issue proceeds, pend_cnt stays 4.
- WAW, err and flush: long rd = 3 pending, second long rd = 3 -> stall. done_rd = 12 when not pending -> err = 1 and stays 1. flush with hazard present -> stall = 0, no allocation.
- Reset mid-flight: 2 ops pending, stall_cycles = 10, assert rst asynchronously -> pend_cnt = 0, sb_full = 0, stall_cycles = 0, err = 0 before the next edge.

Source files
------------

// File: rtl/fwd_scoreboard_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_scoreboard_unit_pkg
//  Description : Shared constants for the forwarding / scoreboard unit:
//                forward-select encodings and the default register width
//                also used by the register file and decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package fwd_scoreboard_unit_pkg;

    // Register address width shared with the regfile and decoder
    localparam int REG_AW_DEF  = 5;

    // Forward select value meaning "take the operand from the register file"
    localparam int SEL_REGFILE = 0;

    // Forward select value for the long-latency completion bus; it sits just
    // above the per-stage selects (stage k -> k+1)
    function automatic int sel_completion(input int fwd_depth);
        return fwd_depth + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_scoreboard_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_scoreboard_unit_if
//  Description : Decode-side bundle between the ID stage and the forwarding /
//                scoreboard unit: source operands, downstream stage
//                destinations, issue and completion info, selects and stall.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fwd_scoreboard_unit_if
    import fwd_scoreboard_unit_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 2)
);
    logic                          flush;
    logic [NUM_SRC*REG_AW-1:0]     id_rs;
    logic [NUM_SRC-1:0]            id_rs_used;
    logic [FWD_DEPTH*REG_AW-1:0]   stage_rd;
    logic [FWD_DEPTH-1:0]          stage_rw;
    logic                          stage_is_load;
    logic                          issue_valid;
    logic                          issue_long;
    logic [REG_AW-1:0]             issue_rd;
    logic                          done_valid;
    logic [REG_AW-1:0]             done_rd;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic                          stall;
    logic                          sb_full;
    logic                          err;
    logic [31:0]                   stall_cycles;

    // Pipeline / decode side
    modport master (
        output flush, id_rs, id_rs_used, stage_rd, stage_rw, stage_is_load,
               issue_valid, issue_long, issue_rd, done_valid, done_rd,
        input  fwd_sel, stall, sb_full, err, stall_cycles
    );

    // Forwarding / scoreboard unit side
    modport slave (
        input  flush, id_rs, id_rs_used, stage_rd, stage_rw, stage_is_load,
               issue_valid, issue_long, issue_rd, done_valid, done_rd,
        output fwd_sel, stall, sb_full, err, stall_cycles
    );

endinterface
`default_nettype wire

// File: rtl/fwd_scoreboard_unit_src_match.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_src_match
//  Description : Priority match of one decode source register against the
//                downstream stage destinations (youngest wins) and then the
//                long-latency completion bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_src_match
    import fwd_scoreboard_unit_pkg::*;
#(
    parameter int FWD_DEPTH = 2,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 2)
) (
    input  wire logic [REG_AW-1:0]           rs,
    input  wire logic                        used,
    input  wire logic [FWD_DEPTH*REG_AW-1:0] stage_rd,
    input  wire logic [FWD_DEPTH-1:0]        stage_rw,
    input  wire logic                        done_valid,
    input  wire logic [REG_AW-1:0]           done_rd,
    output logic      [SEL_W-1:0]            sel,
    output logic                             stage_hit,
    output logic                             done_hit
);

    // Register 0 and unread sources never forward
    logic w_active;
    assign w_active = used && (rs != '0);

    // Scan oldest to youngest so the youngest matching stage overwrites
    always_comb begin
        sel       = SEL_W'(SEL_REGFILE);
        stage_hit = 1'b0;
        done_hit  = done_valid && (done_rd == rs);
        for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
            if (w_active && stage_rw[k] && (stage_rd[k*REG_AW +: REG_AW] == rs)) begin
                sel       = SEL_W'(k + 1);
                stage_hit = 1'b1;
            end
        end
        if (w_active && !stage_hit && done_hit) begin
            sel = SEL_W'(sel_completion(FWD_DEPTH));
        end
    end

endmodule
`default_nettype wire

// File: rtl/fwd_scoreboard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_scoreboard_unit
//  Description : Operand forward selects for the decode stage plus a register
//                scoreboard for in-flight long-latency ops; produces the
//                decode stall for load-use, RAW/WAW on pending and full.
//  Revision    : 1.0 - initial release
// ============================================================================
module fwd_scoreboard_unit
    import fwd_scoreboard_unit_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int FWD_DEPTH = 2,
    parameter int REG_AW    = REG_AW_DEF,
    parameter int MAX_PEND  = 4,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 2)
) (
    input  wire logic             clk,
    input  wire logic             rst,
    fwd_scoreboard_unit_if.slave  bus
);

    localparam int CNT_W  = $clog2(MAX_PEND + 1);
    localparam int NUM_RG = 2 ** REG_AW;

    logic [NUM_RG-1:0]              r_pending;
    logic [CNT_W-1:0]               r_pend_cnt;
    logic                           r_err;
    logic [31:0]                    r_stall_cycles;

    logic [NUM_SRC-1:0][SEL_W-1:0]  w_sel;
    logic [NUM_SRC-1:0]             w_stage_hit;
    logic [NUM_SRC-1:0]             w_done_hit;
    logic                           w_load_use;
    logic                           w_raw_pend;
    logic                           w_waw_pend;
    logic                           w_full_hz;
    logic                           w_full;
    logic                           w_stall;
    logic                           w_alloc;
    logic                           w_clr;
    logic                           w_err_set;

    generate
        for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
            fwd_src_match #(
                .FWD_DEPTH (FWD_DEPTH),
                .REG_AW    (REG_AW),
                .SEL_W     (SEL_W)
            ) u_match (
                .rs         (bus.id_rs[i*REG_AW +: REG_AW]),
                .used       (bus.id_rs_used[i]),
                .stage_rd   (bus.stage_rd),
                .stage_rw   (bus.stage_rw),
                .done_valid (bus.done_valid),
                .done_rd    (bus.done_rd),
                .sel        (w_sel[i]),
                .stage_hit  (w_stage_hit[i]),
                .done_hit   (w_done_hit[i])
            );
        end
    endgenerate

    assign w_full = (r_pend_cnt == CNT_W'(MAX_PEND));

    // Source-side hazards: load data not ready, or reading a pending register
    // that neither a stage nor the completion bus can supply this cycle
    always_comb begin
        w_load_use = 1'b0;
        w_raw_pend = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if ((w_sel[i] == SEL_W'(1)) && bus.stage_is_load) begin
                w_load_use = 1'b1;
            end
            if (bus.id_rs_used[i] && (bus.id_rs[i*REG_AW +: REG_AW] != '0) &&
                r_pending[bus.id_rs[i*REG_AW +: REG_AW]] &&
                !w_stage_hit[i] && !w_done_hit[i]) begin
                w_raw_pend = 1'b1;
            end
        end
    end

    // Destination-side hazards and the resulting stall / allocate / retire
    always_comb begin
        w_waw_pend = bus.issue_valid && (bus.issue_rd != '0) && r_pending[bus.issue_rd] &&
                     !(bus.done_valid && (bus.done_rd == bus.issue_rd));
        // A retiring op frees a slot in the same cycle the new one takes it
        w_full_hz  = bus.issue_valid && bus.issue_long && w_full &&
                     !(bus.done_valid && r_pending[bus.done_rd]);
        w_stall    = !bus.flush && (w_load_use || w_raw_pend || w_waw_pend || w_full_hz);
        w_alloc    = bus.issue_valid && bus.issue_long && !w_stall && !bus.flush &&
                     (bus.issue_rd != '0);
        w_clr      = bus.done_valid && (bus.done_rd != '0) && r_pending[bus.done_rd];
        w_err_set  = bus.done_valid && (bus.done_rd != '0) && !r_pending[bus.done_rd];
    end

    // Scoreboard, occupancy, sticky error and stall counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending      <= '0;
            r_pend_cnt     <= '0;
            r_err          <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            // Set after clear so a same-register alloc/done leaves the bit set
            if (w_clr) begin
                r_pending[bus.done_rd] <= 1'b0;
            end
            if (w_alloc) begin
                r_pending[bus.issue_rd] <= 1'b1;
            end
            case ({w_alloc, w_clr})
                2'b10:   r_pend_cnt <= r_pend_cnt + CNT_W'(1);
                2'b01:   r_pend_cnt <= r_pend_cnt - CNT_W'(1);
                default: r_pend_cnt <= r_pend_cnt;
            endcase
            if (w_err_set) begin
                r_err <= 1'b1;
            end
            if (w_stall && (r_stall_cycles != '1)) begin
                r_stall_cycles <= r_stall_cycles + 32'd1;
            end
        end
    end

    assign bus.fwd_sel      = w_sel;
    assign bus.stall        = w_stall;
    assign bus.sb_full      = w_full;
    assign bus.err          = r_err;
    assign bus.stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fwd_scoreboard_unit
//  Description : Directed bench for fwd_scoreboard_unit with a behavioural
//                model checked every cycle plus literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard_unit;

    localparam int NS   = 2;
    localparam int ND   = 2;
    localparam int AW   = 5;
    localparam int MAXP = 4;
    localparam int SW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    // Behavioural model state
    bit     m_pend [32];
    int     m_cnt  = 0;
    bit     m_err  = 1'b0;
    longint m_sc   = 0;

    fwd_scoreboard_unit_if #(.NUM_SRC(NS), .FWD_DEPTH(ND), .REG_AW(AW), .SEL_W(SW)) bus ();

    fwd_scoreboard_unit #(
        .NUM_SRC(NS), .FWD_DEPTH(ND), .REG_AW(AW), .MAX_PEND(MAXP), .SEL_W(SW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int rs_of(input int i);
        return int'(bus.id_rs[i*AW +: AW]);
    endfunction

    // Operand source from the select rules: youngest stage, then completion bus
    function automatic int exp_sel(input int i);
        int rs = rs_of(i);
        if (!bus.id_rs_used[i] || rs == 0) return 0;
        for (int k = 0; k < ND; k++)
            if (bus.stage_rw[k] && int'(bus.stage_rd[k*AW +: AW]) == rs) return k + 1;
        if (bus.done_valid && int'(bus.done_rd) == rs) return ND + 1;
        return 0;
    endfunction

    function automatic bit exp_stall();
        bit lu = 0, raw = 0, waw, full;
        for (int i = 0; i < NS; i++) begin
            int s = exp_sel(i);
            int rs = rs_of(i);
            if (s == 1 && bus.stage_is_load) lu = 1;
            if (bus.id_rs_used[i] && rs != 0 && m_pend[rs] && !(s >= 1 && s <= ND) &&
                !(bus.done_valid && int'(bus.done_rd) == rs)) raw = 1;
        end
        waw  = bus.issue_valid && bus.issue_rd != 0 && m_pend[bus.issue_rd] &&
               !(bus.done_valid && bus.done_rd == bus.issue_rd);
        full = bus.issue_valid && bus.issue_long && m_cnt == MAXP &&
               !(bus.done_valid && m_pend[bus.done_rd]);
        return !bus.flush && (lu || raw || waw || full);
    endfunction

    // Model state advance
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < 32; r++) m_pend[r] = 0;
            m_cnt = 0; m_err = 0; m_sc = 0;
        end else begin
            bit st, al, cl;
            st = exp_stall();
            al = bus.issue_valid && bus.issue_long && !st && !bus.flush && bus.issue_rd != 0;
            cl = bus.done_valid && bus.done_rd != 0 && m_pend[bus.done_rd];
            if (bus.done_valid && bus.done_rd != 0 && !m_pend[bus.done_rd]) m_err = 1;
            if (cl) m_pend[bus.done_rd] = 0;
            if (al) m_pend[bus.issue_rd] = 1;
            m_cnt = m_cnt + int'(al) - int'(cl);
            if (st && m_sc < 64'hFFFF_FFFF) m_sc++;
        end
    end

    // Compare process: outputs against the model every cycle
    always @(negedge clk) begin
        logic [NS*SW-1:0] es;
        for (int i = 0; i < NS; i++) es[i*SW +: SW] = SW'(exp_sel(i));
        check("fwd_sel",      bus.fwd_sel, es);
        check("stall",        bus.stall, exp_stall());
        check("sb_full",      bus.sb_full, m_cnt == MAXP);
        check("err",          bus.err, m_err);
        check("stall_cycles", bus.stall_cycles, m_sc);
    end

    task automatic idle();
        bus.flush = 0; bus.id_rs = '0; bus.id_rs_used = '0;
        bus.stage_rd = '0; bus.stage_rw = '0; bus.stage_is_load = 0;
        bus.issue_valid = 0; bus.issue_long = 0; bus.issue_rd = '0;
        bus.done_valid = 0; bus.done_rd = '0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk); #1;
    endtask

    task automatic set_rs(input int i, input int r);
        bus.id_rs[i*AW +: AW] = AW'(r);
        bus.id_rs_used[i] = 1'b1;
    endtask

    task automatic set_stage(input int k, input int r, input bit w);
        bus.stage_rd[k*AW +: AW] = AW'(r);
        bus.stage_rw[k] = w;
    endtask

    task automatic issue_long(input int r);
        bus.issue_valid = 1; bus.issue_long = 1; bus.issue_rd = AW'(r);
    endtask

    initial begin
        int guard;
        idle();
        step(); step();
        rst = 0;
        settle();
        check("rst_fwd_sel", bus.fwd_sel, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_sb_full", bus.sb_full, 0);
        check("rst_err", bus.err, 0);

        // Forward priority: youngest stage wins, register 0 never forwards
        step(); idle(); set_rs(0, 5); set_stage(0, 5, 1); set_stage(1, 5, 1);
        settle(); check("prio_young", bus.fwd_sel[SW-1:0], 1); check("prio_stall", bus.stall, 0);
        step(); bus.stage_rw[0] = 0;
        settle(); check("prio_old", bus.fwd_sel[SW-1:0], 2);
        step(); idle(); set_rs(0, 0); set_stage(0, 0, 1);
        settle(); check("prio_r0", bus.fwd_sel, 0);

        // Load-use, then the load moves to stage 1
        step(); idle(); set_stage(0, 7, 1); bus.stage_is_load = 1; set_rs(1, 7);
        settle(); check("ldu_stall", bus.stall, 1);
        step(); idle(); set_stage(1, 7, 1); set_rs(1, 7);
        settle(); check("ldu_clear", bus.stall, 0); check("ldu_sel", bus.fwd_sel[2*SW-1:SW], 2);
        check("ldu_cycles", bus.stall_cycles, 1);

        // Scoreboard RAW: pending, completion-bus bypass, then regfile
        step(); idle(); issue_long(9);
        step(); idle(); set_rs(0, 9);
        settle(); check("raw_stall", bus.stall, 1);
        step(); bus.done_valid = 1; bus.done_rd = 9;
        settle(); check("raw_bypass_stall", bus.stall, 0); check("raw_bypass_sel", bus.fwd_sel[SW-1:0], 3);
        step(); bus.done_valid = 0;
        settle(); check("raw_after_sel", bus.fwd_sel[SW-1:0], 0); check("raw_after_stall", bus.stall, 0);

        // Full scoreboard; same-cycle completion lets the 5th issue through
        for (int r = 1; r <= 4; r++) begin
            step(); idle(); issue_long(r);
        end
        step(); idle();
        settle(); check("full_flag", bus.sb_full, 1);
        issue_long(5);
        settle(); check("full_stall", bus.stall, 1);
        step(); bus.done_valid = 1; bus.done_rd = 1;
        settle(); check("full_pass", bus.stall, 0);
        step(); idle();
        settle(); check("full_keep", bus.sb_full, 1);

        // WAW on pending register 3
        issue_long(3);
        settle(); check("waw_stall", bus.stall, 1);
        // Completion for a non-pending register sets sticky err
        step(); idle(); bus.done_valid = 1; bus.done_rd = 12;
        step(); idle();
        settle(); check("err_set", bus.err, 1);
        for (int r = 2; r <= 5; r++) begin
            step(); idle(); bus.done_valid = 1; bus.done_rd = AW'(r);
        end
        step(); idle(); issue_long(3);
        step(); idle(); issue_long(3);
        settle(); check("waw2_stall", bus.stall, 1); check("err_sticky", bus.err, 1);
        // Flush masks the hazard and blocks allocation
        step(); idle(); bus.flush = 1; set_rs(0, 3); issue_long(6);
        settle(); check("flush_stall", bus.stall, 0);
        step(); idle(); set_rs(0, 6);
        settle(); check("flush_noalloc", bus.stall, 0);

        // Build up stall count with two ops pending, then reset mid-cycle
        step(); idle(); issue_long(8);
        step(); idle(); set_rs(0, 3);
        guard = 0;
        while (m_sc < 10 && guard < 50) begin
            step(); guard++;
        end
        check("sc_reach", (m_sc >= 10) ? 1 : 0, 1);
        @(negedge clk); #2;
        rst = 1;
        #1;
        check("arst_sb_full", bus.sb_full, 0);
        check("arst_cycles", bus.stall_cycles, 0);
        check("arst_err", bus.err, 0);
        check("arst_stall", bus.stall, 0);
        step(); rst = 0;
        step(); idle();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
